// File: rtl/rst_seq_pkg.sv
// Shared state encoding and counter sizing for the power-on reset sequencer.
package rst_seq_pkg;

  typedef enum logic [2:0] {
    PLL_HOLD  = 3'd0,
    WAIT_LOCK = 3'd1,
    RELEASE   = 3'd2,
    RUN       = 3'd3
  } seq_state_t;

  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                            input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/sync_filter.sv
// Two-flop synchroniser followed by a stable-for-N filter; optional instant response to low.
module sync_filter #(
  parameter int unsigned N           = 4,
  parameter bit          INSTANT_LOW = 1'b0,
  parameter bit          RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic filtered
);

  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  logic          s1;
  logic          s2;
  logic          q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1  <= RESET_VAL;
      s2  <= RESET_VAL;
      q   <= RESET_VAL;
      cnt <= '0;
    end else begin
      s1 <= async_in;
      s2 <= s1;
      if (INSTANT_LOW && !s2) begin
        q   <= 1'b0;
        cnt <= '0;
      end else if (s2 == q) begin
        cnt <= '0;
      end else if (cnt == CW'(N - 1)) begin
        q   <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // Gating with s2 makes a loss visible in the same cycle it leaves the synchroniser.
  assign filtered = INSTANT_LOW ? (q & s2) : q;

endmodule

// File: rtl/por_reset_sequencer.sv
// Power-on reset sequencer: PLL hold-up, lock qualification, ordered domain release.
module por_reset_sequencer
  import rst_seq_pkg::*;
#(
  parameter int unsigned NUM_DOMAINS         = 3,
  parameter int unsigned PLL_HOLD_CYCLES     = 128,
  parameter int unsigned LOCK_FILTER_CYCLES  = 64,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 1 << 20,
  parameter int unsigned STAGE_GAP_CYCLES    = 16,
  parameter int unsigned DEBOUNCE_CYCLES     = 1 << 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   btn_reset_n,
  input  logic                   pll_locked,
  output logic                   pll_areset,
  output logic [NUM_DOMAINS-1:0] domain_reset,
  output logic                   seq_done,
  output logic [2:0]             seq_state,
  output logic [7:0]             lock_loss_count,
  output logic [7:0]             retry_count
);

  localparam int unsigned CW = cnt_width(PLL_HOLD_CYCLES, LOCK_TIMEOUT_CYCLES,
                                         STAGE_GAP_CYCLES, LOCK_FILTER_CYCLES);
  localparam int unsigned KW = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  localparam logic [CW-1:0] HOLD_RLD = CW'(PLL_HOLD_CYCLES - 1);
  localparam logic [CW-1:0] TMO_RLD  = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] GAP_RLD  = CW'(STAGE_GAP_CYCLES - 1);
  localparam logic [KW-1:0] K_LAST   = KW'(NUM_DOMAINS - 1);

  logic btn_level;
  logic btn_pressed;
  logic lock_ok;

  sync_filter #(
    .N           (DEBOUNCE_CYCLES),
    .INSTANT_LOW (1'b0),
    .RESET_VAL   (1'b1)
  ) u_btn_filter (
    .clk      (clk),
    .reset    (reset),
    .async_in (btn_reset_n),
    .filtered (btn_level)
  );

  sync_filter #(
    .N           (LOCK_FILTER_CYCLES),
    .INSTANT_LOW (1'b1),
    .RESET_VAL   (1'b0)
  ) u_lock_filter (
    .clk      (clk),
    .reset    (reset),
    .async_in (pll_locked),
    .filtered (lock_ok)
  );

  assign btn_pressed = ~btn_level;

  seq_state_t             state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [KW-1:0]          k_q, k_d;
  logic [NUM_DOMAINS-1:0] dr_q, dr_d;
  logic [7:0]             llc_q, llc_d;
  logic [7:0]             rc_q, rc_d;
  logic                   areset_q;
  logic                   done_q;
  logic                   abort;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    dr_d    = dr_q;
    llc_d   = llc_q;
    rc_d    = rc_q;
    abort   = 1'b0;

    case (state_q)
      PLL_HOLD: begin
        dr_d = '1;
        k_d  = '0;
        if (btn_pressed) begin
          cnt_d = HOLD_RLD;
        end else if (cnt_q == '0) begin
          state_d = WAIT_LOCK;
          cnt_d   = TMO_RLD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      WAIT_LOCK: begin
        abort = btn_pressed;
        if (lock_ok) begin
          state_d = RELEASE;
          cnt_d   = GAP_RLD;
          k_d     = '0;
        end else if (cnt_q == '0) begin
          state_d = PLL_HOLD;
          cnt_d   = HOLD_RLD;
          if (rc_q != 8'hFF) rc_d = rc_q + 8'd1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RELEASE: begin
        abort = btn_pressed || !lock_ok;
        if (cnt_q == '0) begin
          dr_d[k_q] = 1'b0;
          if (k_q == K_LAST) begin
            state_d = RUN;
            cnt_d   = '0;
          end else begin
            k_d   = k_q + KW'(1);
            cnt_d = GAP_RLD;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RUN: begin
        abort = btn_pressed || !lock_ok;
        if (!lock_ok && llc_q != 8'hFF) llc_d = llc_q + 8'd1;
      end
      default: abort = 1'b1;
    endcase

    // Abort overrides any stage/timeout update; lock-loss counting above is kept.
    if (abort) begin
      state_d = PLL_HOLD;
      cnt_d   = HOLD_RLD;
      k_d     = '0;
      dr_d    = '1;
      rc_d    = rc_q;
    end
  end

  // Reset is the entry into PLL_HOLD, so the shared counter takes the hold reload.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= PLL_HOLD;
      cnt_q    <= HOLD_RLD;
      k_q      <= '0;
      dr_q     <= '1;
      llc_q    <= '0;
      rc_q     <= '0;
      areset_q <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      k_q      <= k_d;
      dr_q     <= dr_d;
      llc_q    <= llc_d;
      rc_q     <= rc_d;
      areset_q <= (state_d == PLL_HOLD);
      done_q   <= (state_d == RUN);
    end
  end

  assign pll_areset      = areset_q;
  assign domain_reset    = dr_q;
  assign seq_done        = done_q;
  assign seq_state       = state_q;
  assign lock_loss_count = llc_q;
  assign retry_count     = rc_q;

endmodule

// File: tb/tb_por_reset_sequencer.sv
// Directed scoreboard bench for por_reset_sequencer with short timing parameters.
module tb_por_reset_sequencer;

  localparam int unsigned ND = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          btn_reset_n;
  logic          pll_locked;
  logic          pll_areset;
  logic [ND-1:0] domain_reset;
  logic          seq_done;
  logic [2:0]    seq_state;
  logic [7:0]    lock_loss_count;
  logic [7:0]    retry_count;

  int total = 0;
  int bad   = 0;

  string       tag_q[$];
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  por_reset_sequencer #(
    .NUM_DOMAINS         (ND),
    .PLL_HOLD_CYCLES     (8),
    .LOCK_FILTER_CYCLES  (4),
    .LOCK_TIMEOUT_CYCLES (32),
    .STAGE_GAP_CYCLES    (4),
    .DEBOUNCE_CYCLES     (4)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .btn_reset_n     (btn_reset_n),
    .pll_locked      (pll_locked),
    .pll_areset      (pll_areset),
    .domain_reset    (domain_reset),
    .seq_done        (seq_done),
    .seq_state       (seq_state),
    .lock_loss_count (lock_loss_count),
    .retry_count     (retry_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string t, input logic [31:0] v);
    tag_q.push_back(t);
    exp_q.push_back(v);
  endtask

  task automatic pop_chk(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    t = tag_q.pop_front();
    e = exp_q.pop_front();
    total++;
    assert (obs === e)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", t, obs, e);
    end
  endtask

  task automatic wait_areset(input logic lvl, input int maxc, output int n);
    n = -1;
    for (int i = 1; i <= maxc; i++) begin
      tick();
      if (pll_areset === lvl) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic wait_dr(input logic [ND-1:0] v, input int maxc, output int n);
    n = -1;
    for (int i = 1; i <= maxc; i++) begin
      tick();
      if (domain_reset === v) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic wait_dr_change(input int maxc, output int n, output logic [ND-1:0] v);
    logic [ND-1:0] prev;
    prev = domain_reset;
    n    = -1;
    v    = prev;
    for (int i = 1; i <= maxc; i++) begin
      tick();
      if (domain_reset !== prev) begin
        n = i;
        v = domain_reset;
        break;
      end
    end
  endtask

  task automatic wait_done(input int maxc, output int n);
    n = -1;
    for (int i = 1; i <= maxc; i++) begin
      tick();
      if (seq_done === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic chk_reset_state(input string pfx);
    push({pfx, "_areset"}, 1);  pop_chk(32'(pll_areset));
    push({pfx, "_dr"}, 7);      pop_chk(32'(domain_reset));
    push({pfx, "_done"}, 0);    pop_chk(32'(seq_done));
    push({pfx, "_state"}, 0);   pop_chk(32'(seq_state));
    push({pfx, "_llc"}, 0);     pop_chk(32'(lock_loss_count));
    push({pfx, "_rc"}, 0);      pop_chk(32'(retry_count));
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish, observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int            n;
    logic [ND-1:0] v;

    reset       = 1'b1;
    btn_reset_n = 1'b1;
    pll_locked  = 1'b1;
    repeat (3) tick();
    chk_reset_state("t1_rst");

    // Normal power-up: 8-cycle hold, one cycle to see lock, then 4-cycle stage gaps.
    push("t1_hold_len", 8);
    push("t1_state_release", 2);
    push("t1_gap0", 4); push("t1_dr0", 3'b110); push("t1_done0", 0);
    push("t1_gap1", 4); push("t1_dr1", 3'b100); push("t1_done1", 0);
    push("t1_gap2", 4); push("t1_dr2", 3'b000); push("t1_done2", 1);
    push("t1_state_run", 3);
    reset = 1'b0;
    wait_areset(1'b0, 50, n);
    pop_chk(32'(n));
    tick();
    pop_chk(32'(seq_state));
    for (int s = 0; s < 3; s++) begin
      wait_dr_change(20, n, v);
      pop_chk(32'(n));
      pop_chk(32'(v));
      pop_chk(32'(seq_done));
    end
    pop_chk(32'(seq_state));

    // Lock loss for one cycle in RUN: two more cycles through sync, one to abort.
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    push("t3_abort_lat", 2);
    push("t3_done", 0);
    push("t3_llc", 1);
    push("t3_state", 0);
    push("t3_reseq", 1);
    wait_dr(3'b111, 10, n);
    pop_chk(32'(n));
    pop_chk(32'(seq_done));
    pop_chk(32'(lock_loss_count));
    pop_chk(32'(seq_state));
    wait_dr(3'b110, 60, n);
    pop_chk(32'(n > 0));

    // Synchronous reset mid-release clears everything including lock_loss_count.
    reset = 1'b1;
    tick();
    chk_reset_state("t5");

    // No lock: retry every 32 + 8 cycles.
    pll_locked = 1'b0;
    reset      = 1'b0;
    push("t2_hold0", 8);
    wait_areset(1'b0, 50, n);
    pop_chk(32'(n));
    for (int r = 1; r <= 3; r++) begin
      push("t2_timeout", 32);
      push("t2_retry", 32'(r));
      push("t2_hold", 8);
      wait_areset(1'b1, 60, n);
      pop_chk(32'(n));
      pop_chk(32'(retry_count));
      wait_areset(1'b0, 20, n);
      pop_chk(32'(n));
    end

    // Button: restart cleanly, then glitch, then long press.
    reset      = 1'b1;
    pll_locked = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    push("t4_up", 1);
    push("t4_rc_clr", 0);
    wait_done(100, n);
    pop_chk(32'(n > 0));
    pop_chk(32'(retry_count));

    btn_reset_n = 1'b0;
    repeat (2) tick();
    btn_reset_n = 1'b1;
    repeat (20) tick();
    push("t4_glitch_state", 3);
    push("t4_glitch_dr", 0);
    pop_chk(32'(seq_state));
    pop_chk(32'(domain_reset));

    btn_reset_n = 1'b0;
    push("t4_press_lat", 7);
    push("t4_press_held", 1);
    push("t4_release_hold", 14);
    push("t4_reup", 1);
    wait_dr(3'b111, 20, n);
    pop_chk(32'(n));
    repeat (10 - 7) tick();
    btn_reset_n = 1'b1;
    pop_chk(32'(pll_areset));
    wait_areset(1'b0, 40, n);
    pop_chk(32'(n));
    wait_done(60, n);
    pop_chk(32'(n > 0));

    // Saturation of lock_loss_count.
    for (int i = 0; i < 300; i++) begin
      pll_locked = 1'b0;
      tick();
      pll_locked = 1'b1;
      repeat (5) tick();
      if (i == 99) begin
        push("t6_llc_100", 100);
        pop_chk(32'(lock_loss_count));
      end
      push("t6_relock", 1);
      wait_done(100, n);
      pop_chk(32'(n > 0));
      if (n < 0) break;
    end
    repeat (5) tick();
    push("t6_llc_sat", 255);
    pop_chk(32'(lock_loss_count));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
